mem_pattern_checker: RTL and testbench

- Built-in self-test reader/verifier for the synchronous 8-bit x 256 pattern memory used by the LED demo designs.
- On `start`, fills the memory with a known pattern, then reads every location back and compares it against that pattern. Repeats both phases with the inverted pattern.
- Reports pass/fail, error count and first failing address, and drives a status byte suitable for `out_leds`.
- Sits between a top-level trigger and the memory's single read/write port.

---
 rtl/mem_pattern_checker.sv | 125 ++++++++++++
 tb/tb_mem_pattern_checker.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mem_pattern_checker.sv
// mem_pattern_checker: built-in self-test that fills a single-port RAM with a pattern and verifies it
// Writes E(a) = ~a ^ {phase}, reads it back, then repeats with phase=1 (inverted pattern).
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   start_i               launches a run from IDLE or DONE, ignored while busy
//   mem_addr_o/we_o/wdata_o  RAM port; mem_rdata_i valid one cycle after a read address
//   busy_o, done_o, pass_o   run status; pass_o meaningful only while done_o
//   err_count_o           saturating mismatch count; first_err_addr_o first mismatching address
//   out_leds_o            DONE: {pass, err_count[6:0]}, otherwise {busy, phase, 6'b0}
module mem_pattern_checker #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int ERR_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [ERR_W-1:0]  err_count_o,
  output logic [ADDR_W-1:0] first_err_addr_o,
  output logic [7:0]        out_leds_o
);
  typedef enum logic [2:0] {IDLE, FILL, VERIFY, DRAIN, DONE} state_e;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, caddr_q, caddr_d, first_q, first_d;
  logic              phase_q, phase_d, cv_q, cv_d, ferr_q, ferr_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              we_q, busy_q, done_q, pass_q, busy_d, mismatch;
  logic [DATA_W-1:0] wdata_q;
  logic [7:0]        leds_q;
  // (2^DATA_W-1 - a) mod 2^DATA_W is simply the bitwise inverse of a at DATA_W bits
  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a, input logic p);
    return ~DATA_W'(a) ^ {DATA_W{p}};
  endfunction
  // Read data arrives one cycle after the address, so compares use the delayed address
  assign mismatch = cv_q && (mem_rdata_i != pat(caddr_q, phase_q));
  assign busy_d   = state_d inside {FILL, VERIFY, DRAIN};
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    phase_d = phase_q;
    err_d   = err_q;
    ferr_d  = ferr_q;
    first_d = first_q;
    cv_d    = state_q == VERIFY;
    caddr_d = addr_q;
    if (mismatch) begin
      err_d = &err_q ? err_q : err_q + 1'b1;
      ferr_d = 1'b1;
      first_d = ferr_q ? first_q : caddr_q;
    end
    case (state_q)
      IDLE, DONE: if (start_i) begin
        state_d = FILL;
        addr_d  = '0;
        phase_d = 1'b0;
        err_d   = '0;
        ferr_d  = 1'b0;
        first_d = '0;
      end
      FILL: begin
        addr_d  = addr_q + 1'b1;
        state_d = &addr_q ? VERIFY : FILL;
      end
      VERIFY: begin
        addr_d  = addr_q + 1'b1;
        state_d = &addr_q ? DRAIN : VERIFY;
      end
      DRAIN: begin
        phase_d = 1'b1;
        state_d = phase_q ? DONE : FILL;
      end
      default: state_d = IDLE;
    endcase
  end
  // Outputs are registered from next-state values so they line up with the state they describe
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      caddr_q <= '0;
      first_q <= '0;
      phase_q <= 1'b0;
      cv_q    <= 1'b0;
      ferr_q  <= 1'b0;
      err_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      leds_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      caddr_q <= caddr_d;
      first_q <= first_d;
      phase_q <= phase_d;
      cv_q    <= cv_d;
      ferr_q  <= ferr_d;
      err_q   <= err_d;
      we_q    <= state_d == FILL;
      wdata_q <= state_d == FILL ? pat(addr_d, phase_d) : '0;
      busy_q  <= busy_d;
      done_q  <= state_d == DONE;
      pass_q  <= state_d == DONE && err_d == '0;
      leds_q  <= state_d == DONE ? {err_d == '0, 7'(err_d)} : {busy_d, phase_d, 6'b0};
    end
  end
  assign mem_addr_o       = addr_q;
  assign mem_we_o         = we_q;
  assign mem_wdata_o      = wdata_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign err_count_o      = err_q;
  assign first_err_addr_o = first_q;
  assign out_leds_o       = leds_q;
endmodule

// File: tb/tb_mem_pattern_checker.sv
// tb_mem_pattern_checker: checks mem_pattern_checker against faulty/late RAM models and a small-depth instance
module tb_mem_pattern_checker;
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, start2 = 1'b0, late = 1'b0, clr = 1'b0;
  logic [7:0] addr, wdata, rdata, errc, ferr, leds, errc2, leds2, wdata2, rdata2;
  logic       we, busy, done, pass, we2, busy2, done2, pass2;
  logic [3:0] addr2, ferr2;
  logic [7:0] mem [256];
  logic [7:0] fm [256];
  logic [7:0] fv [256];
  logic [7:0] mem2 [16];
  logic [7:0] rd1, rd2, r2;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  mem_pattern_checker dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mem_addr_o(addr), .mem_we_o(we),
    .mem_wdata_o(wdata), .mem_rdata_i(rdata), .busy_o(busy), .done_o(done), .pass_o(pass),
    .err_count_o(errc), .first_err_addr_o(ferr), .out_leds_o(leds)
  );
  mem_pattern_checker #(.ADDR_W(4)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start2), .mem_addr_o(addr2), .mem_we_o(we2),
    .mem_wdata_o(wdata2), .mem_rdata_i(rdata2), .busy_o(busy2), .done_o(done2), .pass_o(pass2),
    .err_count_o(errc2), .first_err_addr_o(ferr2), .out_leds_o(leds2)
  );
  // Read-first RAM; stuck bits applied on read, optional extra cycle of read latency
  always @(posedge clk) begin
    if (clr) for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    else if (we) mem[addr] <= wdata;
    rd1 <= (mem[addr] & ~fm[addr]) | (fv[addr] & fm[addr]);
    rd2 <= rd1;
    if (we2) mem2[addr2] <= wdata2;
    r2 <= mem2[addr2];
  end
  assign rdata  = late ? rd2 : rd1;
  assign rdata2 = r2;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  // Reference: walk both phases, derive what the faulty RAM returns for each address
  function automatic void model(input bit lt, output int errs, output int first);
    logic [7:0] e, g;
    errs = 0;
    first = -1;
    for (int p = 0; p < 2; p++)
      for (int a = 0; a < 256; a++) begin
        e = 8'((255 - a) ^ (p * 255));
        if (lt) g = (a == 0) ? 8'h00 : 8'((255 - (a - 1)) ^ (p * 255));
        else g = (e & ~fm[a]) | (fv[a] & fm[a]);
        if (g != e) begin
          errs++;
          if (first < 0) first = a;
        end
      end
    if (errs > 255) errs = 255;
    if (first < 0) first = 0;
  endfunction
  task automatic run(input string t, input bit lt, input bit hold);
    int errs, first, n, wk;
    logic [7:0] ea, ed;
    model(lt, errs, first);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 if (!hold) start = 1'b0;
    chk({t, "_busy"}, busy, 1);
    n = 0;
    wk = 0;
    while (!done && n < 3000) begin
      if (we) begin
        ea = 8'(wk % 256);
        ed = 8'((255 - (wk % 256)) ^ ((wk / 256) * 255));
        chk({t, "_waddr"}, addr, ea);
        chk({t, "_wdata"}, wdata, ed);
        wk++;
      end
      @(posedge clk);
      #1 n++;
    end
    chk({t, "_latency"}, n + 1, 2 * (256 + 256 + 1) + 1);
    chk({t, "_writes"}, wk, 512);
    chk({t, "_errc"}, errc, errs);
    chk({t, "_ferr"}, ferr, first);
    chk({t, "_pass"}, pass, errs == 0);
    chk({t, "_leds"}, leds, {errs == 0, 7'(errs)});
    chk({t, "_busy_end"}, busy, 0);
  endtask
  initial begin
    int n, wk, a;
    logic [7:0] ed;
    for (int i = 0; i < 256; i++) begin
      fm[i] = 8'h00;
      fv[i] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1 chk("reset_outs", {we, addr, wdata, busy, done, pass, errc, ferr, leds}, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("idle_busy", {busy, done, we}, 0);
    run("ideal", 0, 0);
    chk("ideal_leds80", leds, 8'h80);
    fm[8'h37] = 8'h01;
    run("stuck37", 0, 0);
    chk("stuck37_leds01", leds, 8'h01);
    fm[8'h37] = 8'h00;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) begin
        a = $urandom_range(255, 0);
        fm[a] = 8'(1 << $urandom_range(7, 0));
        fv[a] = $urandom_range(1, 0) ? 8'hFF : 8'h00;
      end
      run("rand", 0, 0);
      for (int i = 0; i < 256; i++) fm[i] = 8'h00;
    end
    @(negedge clk) clr = 1'b1;
    @(negedge clk) begin
      clr = 1'b0;
      late = 1'b1;
    end
    run("late", 1, 0);
    chk("late_sat", errc, 255);
    @(negedge clk) late = 1'b0;
    run("hold", 0, 1);
    @(posedge clk);
    #1 chk("restart_done", done, 0);
    chk("restart_we", we, 1);
    chk("restart_addr", addr, 0);
    chk("restart_errc", errc, 0);
    chk("restart_busy", busy, 1);
    start = 1'b0;
    n = 0;
    while (!(we && addr == 8'h80 && leds[6]) && n < 2000) begin
      @(posedge clk);
      #1 n++;
    end
    chk("rst_at_addr", addr, 8'h80);
    chk("rst_at_we", we, 1);
    #1 rst_n = 1'b0;
    #1 chk("rst_we_drop", we, 0);
    chk("rst_outs", {addr, wdata, busy, done, pass, errc, ferr, leds}, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("rst_stay_idle", {we, busy, done, leds}, 0);
    @(negedge clk) start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    n = 0;
    wk = 0;
    while (!done2 && n < 500) begin
      if (we2) begin
        ed = 8'((255 - (wk % 16)) ^ ((wk / 16) * 255));
        chk("a4_wdata", wdata2, ed);
        wk++;
      end
      @(posedge clk);
      #1 n++;
    end
    chk("a4_latency", n + 1, 67);
    chk("a4_writes", wk, 32);
    chk("a4_pass", pass2, 1);
    chk("a4_errc", errc2, 0);
    chk("a4_leds", leds2, 8'h80);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
